// File: rtl/radix_multiplier.sv
// rtl/radix_multiplier.sv - pipelined signed/unsigned multiplier retiring CHUNK multiplier bits per stage
// Optional accumulate-at-output feature: define RADIX_MULTIPLIER_ACC_EN.
module radix_multiplier #(
  parameter int WIDTH1 = 8,
  parameter int WIDTH2 = 8,
  parameter int CHUNK  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      in_valid,
  input  logic                      in_signed,
  input  logic [WIDTH1-1:0]         in1,
  input  logic [WIDTH2-1:0]         in2,
`ifdef RADIX_MULTIPLIER_ACC_EN
  input  logic                      in_acc,
`endif
  output logic                      out_valid,
  output logic [WIDTH1+WIDTH2-1:0]  out
);

  localparam int P      = WIDTH1 + WIDTH2;
  localparam int STAGES = WIDTH2 / CHUNK;

  if (WIDTH2 % CHUNK != 0) begin : g_bad_chunk
    $error("radix_multiplier: WIDTH2 must be a multiple of CHUNK");
  end
  if (WIDTH1 < 2 || WIDTH2 < 2) begin : g_bad_width
    $error("radix_multiplier: WIDTH1 and WIDTH2 must be at least 2");
  end

  // Index 0 is the capture register; index k holds the result of stage k.
  logic [STAGES:0] vld_q, vld_d;
  logic [STAGES:0] sgn_q, sgn_d;
  logic [WIDTH1-1:0] mcand_q  [0:STAGES];
  logic [WIDTH1-1:0] mcand_d  [0:STAGES];
  logic [WIDTH2-1:0] mplier_q [0:STAGES];
  logic [WIDTH2-1:0] mplier_d [0:STAGES];
  logic [P-1:0]      sum_q    [0:STAGES];
  logic [P-1:0]      sum_d    [0:STAGES];
`ifdef RADIX_MULTIPLIER_ACC_EN
  logic [STAGES:0] acc_q, acc_d;
`endif

  logic              out_valid_q, out_valid_d;
  logic [P-1:0]      out_q, out_d;

  logic [P-1:0]      a_ext;
  logic [P-1:0]      row;
  logic [CHUNK-1:0]  digit;

  always_comb begin
    vld_d = vld_q;
    sgn_d = sgn_q;
`ifdef RADIX_MULTIPLIER_ACC_EN
    acc_d = acc_q;
`endif
    for (int k = 0; k <= STAGES; k++) begin
      mcand_d[k]  = mcand_q[k];
      mplier_d[k] = mplier_q[k];
      sum_d[k]    = sum_q[k];
    end
    a_ext       = '0;
    row         = '0;
    digit       = '0;
    out_valid_d = vld_q[STAGES];
    out_d       = out_q;

    vld_d[0] = in_valid;
    sum_d[0] = '0;
    if (in_valid) begin
      mcand_d[0]  = in1;
      mplier_d[0] = in2;
      sgn_d[0]    = in_signed;
`ifdef RADIX_MULTIPLIER_ACC_EN
      acc_d[0]    = in_acc;
`endif
    end

    for (int k = 1; k <= STAGES; k++) begin
      vld_d[k] = vld_q[k-1];
      if (vld_q[k-1]) begin
        a_ext = {{WIDTH2{sgn_q[k-1] & mcand_q[k-1][WIDTH1-1]}}, mcand_q[k-1]};
        digit = mplier_q[k-1][CHUNK-1:0];
        row   = '0;
        // The multiplier MSB carries weight -2^(WIDTH2-1) in signed mode.
        for (int j = 0; j < CHUNK; j++) begin
          if (digit[j]) begin
            if (sgn_q[k-1] && (k == STAGES) && (j == CHUNK - 1))
              row = row - (a_ext << ((k - 1) * CHUNK + j));
            else
              row = row + (a_ext << ((k - 1) * CHUNK + j));
          end
        end
        sum_d[k]    = sum_q[k-1] + row;
        mcand_d[k]  = mcand_q[k-1];
        mplier_d[k] = mplier_q[k-1] >> CHUNK;
        sgn_d[k]    = sgn_q[k-1];
`ifdef RADIX_MULTIPLIER_ACC_EN
        acc_d[k]    = acc_q[k-1];
`endif
      end
    end

    if (vld_q[STAGES]) begin
`ifdef RADIX_MULTIPLIER_ACC_EN
      out_d = acc_q[STAGES] ? (out_q + sum_q[STAGES]) : sum_q[STAGES];
`else
      out_d = sum_q[STAGES];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q       <= '0;
      sgn_q       <= '0;
`ifdef RADIX_MULTIPLIER_ACC_EN
      acc_q       <= '0;
`endif
      for (int k = 0; k <= STAGES; k++) begin
        mcand_q[k]  <= '0;
        mplier_q[k] <= '0;
        sum_q[k]    <= '0;
      end
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (en) begin
      vld_q       <= vld_d;
      sgn_q       <= sgn_d;
`ifdef RADIX_MULTIPLIER_ACC_EN
      acc_q       <= acc_d;
`endif
      for (int k = 0; k <= STAGES; k++) begin
        mcand_q[k]  <= mcand_d[k];
        mplier_q[k] <= mplier_d[k];
        sum_q[k]    <= sum_d[k];
      end
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;

endmodule

// File: tb/tb_radix_multiplier.sv
// tb/tb_radix_multiplier.sv - randomized self-checking bench for radix_multiplier
// Honours RADIX_MULTIPLIER_ACC_EN in both the port list and the reference model.
module tb_radix_multiplier;

  localparam int W1 = 8;
  localparam int W2 = 8;
  localparam int LAT = 5;

  logic        clk;
  logic        rst;
  logic        en;
  logic        in_valid;
  logic        in_signed;
  logic [7:0]  in1;
  logic [7:0]  in2;
  logic        in_acc;
  logic        out_valid;
  logic [15:0] out;

  radix_multiplier #(.WIDTH1(W1), .WIDTH2(W2), .CHUNK(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_signed (in_signed),
    .in1       (in1),
    .in2       (in2),
`ifdef RADIX_MULTIPLIER_ACC_EN
    .in_acc    (in_acc),
`endif
    .out_valid (out_valid),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          edge_no;
    logic [15:0] val;
    bit          acc;
  } exp_t;

  exp_t        pending[$];
  int          checks = 0;
  int          errors = 0;
  int          edge_cnt = 0;
  logic [15:0] model_out = 16'h0;
  logic        model_valid = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_product(input bit s, input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa, sb;
    if (s) begin
      sa = $signed({{8{a[7]}}, a});
      sb = $signed({{8{b[7]}}, b});
      return 16'(sa * sb);
    end
    return 16'({8'h00, a} * {8'h00, b});
  endfunction

  // Drive one cycle, then check the output against the model just after the edge.
  task automatic step(input bit en_i, input bit v, input bit s,
                      input logic [7:0] a, input logic [7:0] b, input bit acc);
    exp_t e;
    en = en_i; in_valid = v; in_signed = s; in1 = a; in2 = b; in_acc = acc;
    @(posedge clk);
    #1;
    if (en_i) begin
      edge_cnt++;
      if (v) begin
        e.edge_no = edge_cnt;
        e.val     = ref_product(s, a, b);
`ifdef RADIX_MULTIPLIER_ACC_EN
        e.acc     = acc;
`else
        e.acc     = 1'b0;
`endif
        pending.push_back(e);
      end
      model_valid = 1'b0;
      if (pending.size() > 0 && pending[0].edge_no + LAT == edge_cnt) begin
        e = pending.pop_front();
        model_valid = 1'b1;
        model_out = e.acc ? 16'(model_out + e.val) : e.val;
      end
      check_eq("out_valid", {31'b0, out_valid}, {31'b0, model_valid});
      check_eq("out", {16'b0, out}, {16'b0, model_out});
    end else begin
      check_eq("stall_out_valid", {31'b0, out_valid}, {31'b0, model_valid});
      check_eq("stall_out", {16'b0, out}, {16'b0, model_out});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; in_valid = 1'b0; in_signed = 1'b0;
    in1 = 8'h0; in2 = 8'h0; in_acc = 1'b0;
    #2;
    check_eq("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("reset_out", {16'b0, out}, 32'd0);
    #10;
    rst = 1'b1;

    // Full-scale unsigned and latency.
    step(1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0);
    idle(LAT + 1);
    check_eq("full_scale", {16'b0, out}, 32'h0000FE01);

    // Signed corners back-to-back.
    step(1'b1, 1'b1, 1'b1, 8'h80, 8'h80, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'hFF, 8'h01, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'hFF, 8'h01, 1'b0);
    idle(LAT + 1);
    check_eq("unsigned_ff_01", {16'b0, out}, 32'h000000FF);

    // Stream with a three-cycle stall after the fourth issue.
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'(i), 8'(i + 1), 1'b0);
      if (i == 4) for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    end
    idle(LAT + 1);
    check_eq("stream_last", {16'b0, out}, 32'd110);

    // Bubbles between two results.
    step(1'b1, 1'b1, 1'b0, 8'd3, 8'd7, 1'b0);
    idle(2);
    step(1'b1, 1'b1, 1'b0, 8'd9, 8'd9, 1'b0);
    idle(LAT + 1);

    // Asynchronous reset with three transactions in flight.
    step(1'b1, 1'b1, 1'b0, 8'd11, 8'd12, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'd200, 8'd3, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'd5, 8'd5, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_eq("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("async_rst_out", {16'b0, out}, 32'd0);
    pending.delete();
    model_out = 16'h0;
    model_valid = 1'b0;
    #2;
    rst = 1'b1;
    idle(LAT + 1);

    // Accumulate sequence: 12,42,46 with the feature, else 12,30,4.
    step(1'b1, 1'b1, 1'b0, 8'd3, 8'd4, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'd5, 8'd6, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'd2, 8'd2, 1'b1);
    idle(LAT + 1);
`ifdef RADIX_MULTIPLIER_ACC_EN
    check_eq("acc_final", {16'b0, out}, 32'd46);
`else
    check_eq("acc_final", {16'b0, out}, 32'd4);
`endif

    // Randomized traffic with stalls and bubbles.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, 1'($urandom),
           8'($urandom), 8'($urandom), 1'($urandom));
    end
    idle(LAT + 1);
    check_eq("drained", pending.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
